dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache plus its controller FSM.
//  Sits between the CPU load/store stage and the byte-addressed data memory.
//  Serves load hits with no stall and sequences refills and stores to memory.
//  Stalls the pipeline until the memory handshake (mem_ready) completes.
//  Keeps hit/miss statistics counters.
// PARAMETERS
//  INDEX_BITS  3   log2 of line count; one 32-bit word per line (8 lines)
//  ADDR_WIDTH  17  memory address bits used; tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]
//  CNT_WIDTH   16  width of hit_cnt / miss_cnt
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  cpu_req    in   1   load/store request valid; held stable by CPU while stall=1
//  cpu_we     in   3   bit0=store, bit1=byte access (3'b001 sw, 3'b011 sb, 3'b000 lw, 3'b010 lb)
//  cpu_addr   in   32  byte address
//  cpu_wdata  in   32  store data (sb uses [7:0])
//  cpu_rdata  out  32  aligned word at {cpu_addr[31:2],2'b0}; byte select is done by the CPU
//  stall      out  1   hold pipeline this cycle
//  mem_we     out  3   memory write enable, same encoding as cpu_we
//  mem_addr   out  32  memory address: {cpu_addr[31:2],2'b0} for loads, cpu_addr for stores
//  mem_wdata  out  32  = cpu_wdata
//  mem_rdata  in   32  word returned by memory (async read)
//  mem_ready  in   1   memory idle / previous write committed
//  hit_cnt    out  CNT_WIDTH  saturating count of load hits
//  miss_cnt   out  CNT_WIDTH  saturating count of load misses
// BEHAVIOUR
//  Reset: state=IDLE; all valid bits=0; hit_cnt=miss_cnt=0; mem_we=0; stall=0.
//  Tag/data arrays are not reset.
//  hit = valid[idx] && tag[idx]==addr tag; idx = cpu_addr[INDEX_BITS+1:2].
//  stall (comb) = (state==REFILL||state==WRITE) || (state==IDLE && cpu_req && (cpu_we[0] || !hit)).
//  IDLE:
//   - cpu_req=0: stay.
//   - load hit: cpu_rdata=line data in same cycle, stall=0, hit_cnt++.
//   - load miss: miss_cnt++, go to REFILL.
//   - store: go to WRITE. On a hit, merge into the cached line (sw: whole word; sb: byte lane addr[1:0]).
//     On a miss, the cache is unchanged.
//  REFILL:
//   - mem_we=0; mem_addr=word address.
//   - When mem_ready=1: write mem_rdata into data[idx], tag, valid=1, then go to IDLE.
//   - The next cycle hits; minimum load-miss penalty is 2 stall cycles.
//  WRITE:
//   - First cycle: mem_we=cpu_we (one-cycle pulse tracked by an internal issued flag). Later cycles: mem_we=0.
//   - After the pulse, wait for mem_ready=1, then go to DONE.
//  DONE:
//   - stall=0 for exactly 1 cycle so the CPU retires the store; the held request is ignored.
//   - Then go to IDLE.
//  mem_we is never nonzero outside the first WRITE cycle.
//  Loads never write memory.
//  Counters saturate at all-ones and do not wrap.
//  Only loads are counted; stores are not counted.
//  Reset mid-REFILL/WRITE: immediate return to IDLE, mem_we=0, and the pending line is not filled.
//  A write already pulsed is not retracted.
//  cpu_we values 3'b1x0 are treated as loads.
// TESTING
//  1 Reset, then lw 0x10000 (mem=0xDEADBEEF):
//    stall=1 for 2 cycles, then rdata=0xDEADBEEF with stall=0; miss_cnt=1, hit_cnt=1.
//  2 Repeat lw 0x10000:
//    stall=0 in the same cycle, rdata=0xDEADBEEF, hit_cnt=2, and no memory access.
//  3 sb 0x10001 with wdata=0x55 after test 2:
//    a single mem_we=3'b011 pulse; DONE stall=0; next lw 0x10000 hits with 0xDEAD55EF.
//  4 lw 0x10020 (same idx, new tag) after test 3:
//    miss and refill evicts the line; following lw 0x10000 misses again; miss_cnt=3.
//  5 sw 0x10040 with mem_ready held low for 5 cycles:
//    mem_we pulses for only 1 cycle; stall stays 1 until mem_ready=1, then 1 cycle of stall=0.
//  6 Assert rst_n=0 during REFILL:
//    mem_we=0, stall=0 immediately; after release, lw of the same address misses again.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache and its controller.
// One 32-bit word per line. Load hits return data in the request cycle with no stall. Load
// misses refill the line from memory. Stores are always written through to memory, and they
// update the cached line only when the store hits.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cpu_req/we/addr     CPU request; the CPU holds these stable while stall=1
//   cpu_wdata           store data (a byte store uses [7:0])
//   cpu_rdata           word-aligned line data for cpu_addr
//   stall               hold the pipeline this cycle
//   mem_we/addr/wdata   memory write enable (cpu_we encoding), address and write data
//   mem_rdata           asynchronous read data from memory
//   mem_ready           memory idle / previous write committed
//   hit_cnt, miss_cnt   saturating counts of load hits and load misses
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic [2:0]           cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 stall,
  output logic [2:0]           mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned TagW  = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRefill = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic                 issued_q, issued_d;
  logic [Lines-1:0]     valid_q;
  logic [TagW-1:0]      tag_q [Lines];
  logic [31:0]          data_q [Lines];
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TagW-1:0]       addr_tag;
  logic                  is_store, hit, idle_req, fill_en, merge_en;
  logic                  load_hit, load_miss;
  logic [31:0]           merged;

  assign idx       = cpu_addr[INDEX_BITS+1:2];
  assign addr_tag  = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  // cpu_we 3'b1x0 has bit0 clear, so it takes the load path.
  assign is_store  = cpu_we[0];
  assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign idle_req  = (state_q == StIdle) && cpu_req;
  assign load_hit  = idle_req && !is_store && hit;
  assign load_miss = idle_req && !is_store && !hit;
  assign fill_en   = (state_q == StRefill) && mem_ready;
  // On a store hit, the line is updated in the request cycle. The memory write follows.
  assign merge_en  = idle_req && is_store && hit;

  always_comb begin
    merged = data_q[idx];
    if (cpu_we[1]) begin
      case (cpu_addr[1:0])
        2'd0:    merged[7:0]   = cpu_wdata[7:0];
        2'd1:    merged[15:8]  = cpu_wdata[7:0];
        2'd2:    merged[23:16] = cpu_wdata[7:0];
        default: merged[31:24] = cpu_wdata[7:0];
      endcase
    end else begin
      merged = cpu_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (is_store) begin
            state_d = StWrite;
          end else if (!hit) begin
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        if (mem_ready) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        // The first WRITE cycle issues the pulse. mem_ready is only trusted after the pulse.
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (mem_ready) begin
          state_d  = StDone;
          issued_d = 1'b0;
        end
      end
      default: state_d = StIdle;  // DONE: one unstalled cycle, held request ignored
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      issued_q   <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
      end
      if (load_hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CntOne;
      end
      if (load_miss && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CntOne;
      end
    end
  end

  // Tag and data arrays are not reset. Validity is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= addr_tag;
      data_q[idx] <= mem_rdata;
    end else if (merge_en) begin
      data_q[idx] <= merged;
    end
  end

  // Outputs are forced quiet while reset is asserted, even if a request is still held.
  assign stall = rst_n && ((state_q == StRefill) || (state_q == StWrite) ||
                           (idle_req && (is_store || !hit)));
  assign mem_we    = (rst_n && (state_q == StWrite) && !issued_q) ? cpu_we : 3'b000;
  assign mem_addr  = is_store ? cpu_addr : {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;
  assign cpu_rdata = data_q[idx];
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl. The bench acts as a 32-word memory at 0x10000. It compares the DUT
// against a transaction-level model of the cache. The model keeps one valid bit and one tag per
// line and holds the expected memory contents. A second instance with a 3-bit counter width
// receives the same stimulus so that counter saturation is exercised.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [2:0]  cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic [2:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_cnt, miss_cnt;

  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic        s_stall;
  logic [2:0]  s_mem_we;
  logic [2:0]  s_hit, s_miss;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dcache_ctrl #(.CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata), .stall(s_stall), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(s_hit), .miss_cnt(s_miss)
  );

  // Memory device. It is written only from the DUT's mem_we, or by a preload from the model.
  logic [31:0] dev_mem [32];
  logic [31:0] ref_mem [32];
  logic        preload;
  assign mem_rdata = dev_mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= ref_mem[i];
    end else if (mem_we != 3'b000) begin
      if (mem_we[1]) begin
        case (mem_addr[1:0])
          2'd0:    dev_mem[mem_addr[6:2]][7:0]   <= mem_wdata[7:0];
          2'd1:    dev_mem[mem_addr[6:2]][15:8]  <= mem_wdata[7:0];
          2'd2:    dev_mem[mem_addr[6:2]][23:16] <= mem_wdata[7:0];
          default: dev_mem[mem_addr[6:2]][31:24] <= mem_wdata[7:0];
        endcase
      end else begin
        dev_mem[mem_addr[6:2]] <= mem_wdata;
      end
    end
  end

  // Reference model state
  bit ref_valid [8];
  int ref_tag   [8];
  int ref_hit, ref_miss;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [2:0] we,
                                             input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (we[1]) r[lane*8 +: 8] = wd[7:0];
    else r = wd;
    return r;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, "_hit"}, 32'(hit_cnt), 32'(ref_hit));
    check_eq({tag, "_miss"}, 32'(miss_cnt), 32'(ref_miss));
    check_eq({tag, "_sat_hit"}, 32'(s_hit), 32'(sat(ref_hit, 7)));
    check_eq({tag, "_sat_miss"}, 32'(s_miss), 32'(sat(ref_miss, 7)));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end
    ref_hit  = 0;
    ref_miss = 0;
  endtask

  // One CPU transaction, starting at a negedge. While the bench is inside the transaction,
  // mem_ready is held low on cycles 0 to r-1 and driven high from cycle r onward.
  task automatic do_txn(input logic [2:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int r, output logic [31:0] rdata_seen);
    logic        st, exp_hit;
    int          ix, tg, w, exp_free, cyc, pulses;
    logic [2:0]  p_we;
    logic [31:0] p_addr, p_wdata;
    st = we[0];
    ix = int'(addr[4:2]);
    tg = int'(addr[16:5]);
    w  = int'(addr[6:2]);
    exp_hit = ref_valid[ix] && (ref_tag[ix] == tg);
    // A store is unstalled in DONE. DONE comes after the pulse cycle and the first ready
    // cycle. A load miss is unstalled on the cycle after the refill completes.
    if (st) exp_free = ((r > 2) ? r : 2) + 1;
    else if (exp_hit) exp_free = 0;
    else exp_free = ((r > 1) ? r : 1) + 1;

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    pulses = 0; p_we = '0; p_addr = '0; p_wdata = '0;
    cyc = 0;
    while (cyc < 40) begin
      mem_ready = (cyc >= r);
      #1;
      if (mem_we != 3'b000) begin
        if (pulses == 0) begin
          p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
        end
        pulses++;
      end
      if (!st && !exp_hit && cyc == 1) check_eq("refill_addr", mem_addr, {addr[31:2], 2'b00});
      if (!stall) break;
      @(negedge clk);
      cyc++;
    end
    rdata_seen = cpu_rdata;
    check_eq("unstall_cycle", 32'(cyc), 32'(exp_free));
    if (!st) check_eq("load_rdata", cpu_rdata, ref_mem[w]);
    check_eq("mem_we_pulses", 32'(pulses), st ? 32'd1 : 32'd0);
    if (st) begin
      check_eq("pulse_we", 32'(p_we), 32'(we));
      check_eq("pulse_addr", p_addr, addr);
      check_eq("pulse_wdata", p_wdata, wdata);
    end

    if (st) begin
      ref_mem[w] = merge_word(ref_mem[w], we, addr[1:0], wdata);
    end else begin
      if (!exp_hit) begin
        ref_miss++;
        ref_valid[ix] = 1'b1;
        ref_tag[ix]   = tg;
      end
      ref_hit++;  // a miss is followed by the hit cycle that delivers the data
    end

    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b1;
    #1;
    check_counters("cnt");
  endtask

  // Reset is asserted while the request waits for memory: in REFILL for a load, or in WRITE
  // after the pulse for a store. The held request stays asserted while reset goes low.
  task automatic reset_mid(input logic [2:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int w;
    w = int'(addr[6:2]);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_reset_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_mem_we", 32'(mem_we), 32'd0);
    clear_model();
    check_counters("reset_cnt");
    if (we[0]) ref_mem[w] = merge_word(ref_mem[w], we, addr[1:0], wdata);
    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  we_tab [6];
    logic [2:0]  we;
    logic [31:0] addr;
    int          ts, ix, b, r;

    we_tab[0] = 3'b000; we_tab[1] = 3'b010; we_tab[2] = 3'b001;
    we_tab[3] = 3'b011; we_tab[4] = 3'b100; we_tab[5] = 3'b110;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 3'b000; cpu_addr = 32'h0001_0000;
    cpu_wdata = '0; mem_ready = 1'b1; preload = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'hDEAD_BEEF;
    clear_model();
    repeat (2) @(negedge clk);
    preload = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_counters("rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: cold load miss with a minimum refill
    do_txn(3'b000, 32'h0001_0000, 32'h0, 1, rd);
    check_eq("t1_rdata", rd, 32'hDEAD_BEEF);
    check_eq("t1_miss", 32'(miss_cnt), 32'd1);
    check_eq("t1_hit", 32'(hit_cnt), 32'd1);
    // 2: load hit
    do_txn(3'b000, 32'h0001_0000, 32'h0, 0, rd);
    check_eq("t2_hit", 32'(hit_cnt), 32'd2);
    // 3: byte store hit, then a reload
    do_txn(3'b011, 32'h0001_0001, 32'h0000_0055, 0, rd);
    do_txn(3'b000, 32'h0001_0000, 32'h0, 0, rd);
    check_eq("t3_rdata", rd, 32'hDEAD_55EF);
    // 4: conflict eviction
    do_txn(3'b000, 32'h0001_0020, 32'h0, 0, rd);
    do_txn(3'b000, 32'h0001_0000, 32'h0, 2, rd);
    check_eq("t4_miss", 32'(miss_cnt), 32'd3);
    // 5: word store with mem_ready low for 5 cycles
    do_txn(3'b001, 32'h0001_0040, 32'hCAFE_F00D, 5, rd);
    // 6: reset during REFILL. The line is not filled, so the same load misses again.
    reset_mid(3'b000, 32'h0001_0060, 32'h0);
    do_txn(3'b000, 32'h0001_0060, 32'h0, 1, rd);
    do_txn(3'b000, 32'h0001_0060, 32'h0, 0, rd);
    // Reset after the store pulse. The memory write stands.
    reset_mid(3'b001, 32'h0001_0044, 32'h1234_5678);
    do_txn(3'b000, 32'h0001_0044, 32'h0, 0, rd);
    check_eq("t6_store_kept", rd, 32'h1234_5678);

    for (int n = 0; n < 300; n++) begin
      we   = we_tab[$urandom_range(0, 5)];
      ts   = int'($urandom_range(0, 3));
      ix   = int'($urandom_range(0, 7));
      b    = we[1] ? int'($urandom_range(0, 3)) : 0;
      addr = 32'h0001_0000 + 32'(ts * 32 + ix * 4 + b);
      r    = int'($urandom_range(0, 4));
      do_txn(we, addr, $urandom, r, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
